ps2_rx_frame: RTL and testbench

- Upstream stage of scan_codes: receives PS/2 keyboard frames on raw ps2_clk/ps2_data lines and produces the 16-bit code and one-cycle status strobe that scan_codes consumes.
- Synchronizes the PS/2 lines and samples data on falling ps2_clk edges.
- Validates start, parity and stop bits.
- Shifts each good byte into a 2-byte history, so a break sequence F0 xx appears as code = 16'hF0xx.

---
 rtl/ps2_rx_frame_if.sv | 12 +
 rtl/ps2_rx_frame.sv | 110 +++++++++++
 tb/tb_ps2_rx_frame.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ps2_rx_frame_if.sv
// PS/2 receive-side bundle: raw line inputs plus decoded code/strobe outputs.
interface ps2_rx_frame_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [15:0] code;
  logic        status;
  logic        err;
  logic        busy;

  modport master (output ps2_clk, ps2_data, input code, status, err, busy);
  modport slave  (input ps2_clk, ps2_data, output code, status, err, busy);
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 keyboard frame receiver feeding scan_codes: sync, falling-edge sample, 2-byte history.
// Define PS2_RX_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_rx_frame #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic           clk,
  input  logic           rst_n,
  ps2_rx_frame_if.slave  bus
);
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_TERM = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic                   clk_prev_q;
  logic [2:0]             bit_q;
  logic [7:0]             shift_q;
  logic [TW-1:0]          tmo_q;
  logic [15:0]            code_q;
  logic                   status_q, err_q;
`ifdef PS2_RX_PARITY_CHECK_EN
  logic                   par_q;
`endif

  logic clk_s, din, fall, frame_ok;
  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign din   = dat_sync_q[SYNC_STAGES-1];
  assign fall  = clk_prev_q & ~clk_s;

  // Stop bit is the current sample; odd parity covers the 8 data bits plus parity.
  always_comb begin
    frame_ok = din;
`ifdef PS2_RX_PARITY_CHECK_EN
    frame_ok = din & (^{shift_q, par_q});
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
      bit_q      <= '0;
      shift_q    <= '0;
      tmo_q      <= '0;
      code_q     <= '0;
      status_q   <= 1'b0;
      err_q      <= 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
      par_q      <= 1'b0;
`endif
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], bus.ps2_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], bus.ps2_data};
      clk_prev_q <= clk_s;
      status_q   <= 1'b0;
      err_q      <= 1'b0;
      // An edge landing on the terminal count wins over the timeout.
      if (fall) begin
        tmo_q <= '0;
        case (state_q)
          IDLE: if (!din) begin
            state_q <= DATA;
            bit_q   <= '0;
          end
          DATA: begin
            shift_q <= {din, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
`ifdef PS2_RX_PARITY_CHECK_EN
            par_q   <= din;
`endif
            state_q <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            if (frame_ok) begin
              code_q   <= {code_q[7:0], shift_q};
              status_q <= 1'b1;
            end else begin
              err_q    <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end else if (state_q != IDLE) begin
        if (tmo_q == TMO_TERM) begin
          state_q <= IDLE;
          err_q   <= 1'b1;
          tmo_q   <= '0;
        end else begin
          tmo_q   <= tmo_q + 1'b1;
        end
      end else begin
        tmo_q <= '0;
      end
    end
  end

  assign bus.code   = code_q;
  assign bus.status = status_q;
  assign bus.err    = err_q;
  assign bus.busy   = (state_q != IDLE);
endmodule

// File: tb/tb_ps2_rx_frame.sv
// Directed bench for ps2_rx_frame: table of frames plus reset/timeout sequences.
module tb_ps2_rx_frame;
  localparam int TMO = 100;
`ifdef PS2_RX_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ps2_rx_frame_if bus();
  ps2_rx_frame #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_st = 0, n_err = 0, n_both = 0, last_err_cyc = 0;
  always @(negedge clk) begin
    if (bus.status) n_st = n_st + 1;
    if (bus.err) begin
      n_err = n_err + 1;
      last_err_cyc = cyc;
    end
    if (bus.status && bus.err) n_both = n_both + 1;
  end

  typedef struct {
    logic [7:0]  data;
    logic        pflip;
    logic        stop;
    logic [15:0] exp_code;
    int          exp_st;
    int          exp_err;
  } vec_t;
  vec_t tv [6];

  int errors = 0, checks = 0;
  int last_fall = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    wait_clk(10);
    bus.ps2_data = b;
    wait_clk(10);
    bus.ps2_clk = 1'b0;
    last_fall = cyc;
    wait_clk(20);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit((~^d) ^ pflip);
    ps2_bit(stop);
    wait_clk(10);
  endtask

  task automatic check_outs_zero(input string tag);
    @(negedge clk);
    chk({tag, "_code"}, 32'(bus.code), 32'h0);
    chk({tag, "_status"}, 32'(bus.status), 32'h0);
    chk({tag, "_err"}, 32'(bus.err), 32'h0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
  endtask

  initial begin
    int s0, e0, delta;
    tv[0] = '{8'hF0, 1'b0, 1'b1, 16'h00F0, 1, 0};
    tv[1] = '{8'h16, 1'b0, 1'b1, 16'hF016, 1, 0};
    tv[2] = '{8'h1E, 1'b0, 1'b0, 16'hF016, 0, 1};
    tv[3] = '{8'h1E, 1'b0, 1'b1, 16'h161E, 1, 0};
    tv[4] = '{8'h26, 1'b1, 1'b1, PAR_EN ? 16'h161E : 16'h1E26, PAR_EN ? 0 : 1, PAR_EN ? 1 : 0};
    tv[5] = '{8'h45, 1'b0, 1'b1, PAR_EN ? 16'h1E45 : 16'h2645, 1, 0};

    // Reset held while the PS/2 clock toggles with data low.
    rst_n = 1'b0;
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_clk(20);
      bus.ps2_clk = ~bus.ps2_clk;
      check_outs_zero("reset");
    end
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(5);

    // Single byte
    s0 = n_st; e0 = n_err;
    send_frame(8'h16, 1'b0, 1'b1);
    chk("single_status", 32'(n_st - s0), 32'd1);
    chk("single_err", 32'(n_err - e0), 32'd0);
    chk("single_code", 32'(bus.code), 32'h0016);
    chk("single_busy", 32'(bus.busy), 32'h0);

    // Fall with data high in IDLE is not a start bit
    e0 = n_err;
    ps2_bit(1'b1);
    wait_clk(5);
    chk("nostart_busy", 32'(bus.busy), 32'h0);
    chk("nostart_err", 32'(n_err - e0), 32'd0);

    rst_n = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(3);

    for (int i = 0; i < 6; i++) begin
      s0 = n_st; e0 = n_err;
      send_frame(tv[i].data, tv[i].pflip, tv[i].stop);
      chk($sformatf("tv%0d_code", i), 32'(bus.code), 32'(tv[i].exp_code));
      chk($sformatf("tv%0d_status", i), 32'(n_st - s0), 32'(tv[i].exp_st));
      chk($sformatf("tv%0d_err", i), 32'(n_err - e0), 32'(tv[i].exp_err));
      chk($sformatf("tv%0d_busy", i), 32'(bus.busy), 32'h0);
    end

    // Timeout: start bit plus 3 data bits, then lines idle.
    s0 = n_st; e0 = n_err;
    ps2_bit(1'b0);
    ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    chk("tmo_busy_mid", 32'(bus.busy), 32'h1);
    for (int i = 0; i < 300 && n_err == e0; i++) @(posedge clk);
    wait_clk(2);
    delta = last_err_cyc - last_fall;
    chk("tmo_err_count", 32'(n_err - e0), 32'd1);
    chk("tmo_latency_ok", 32'(delta >= TMO && delta <= TMO + 6), 32'd1);
    if (!(delta >= TMO && delta <= TMO + 6)) $display("  timeout latency was %0d cycles", delta);
    chk("tmo_status", 32'(n_st - s0), 32'd0);
    chk("tmo_busy", 32'(bus.busy), 32'h0);
    chk("tmo_code", 32'(bus.code), 32'(tv[5].exp_code));

    // Reset mid-frame, then a fresh frame.
    ps2_bit(1'b0);
    ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    rst_n = 1'b0;
    check_outs_zero("midrst");
    wait_clk(5);
    bus.ps2_data = 1'b1;
    rst_n = 1'b1;
    wait_clk(5);
    s0 = n_st;
    send_frame(8'h45, 1'b0, 1'b1);
    chk("post_rst_code", 32'(bus.code), 32'h0045);
    chk("post_rst_status", 32'(n_st - s0), 32'd1);

    chk("no_status_err_overlap", 32'(n_both), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
